hazard_ctrl: RTL

- Pipeline hazard controller for the 5-stage rv32i pipeline.
- Sits beside the ID/EX boundary, directly upstream of the EX-stage forwarding unit.
- Generates stall, bubble and flush controls so that every instruction entering EX either has its operands available in the register file or has them forwardable from MEM/WB.
- Handles four hazard sources: load-use hazards, taken-branch/jump flushes, data-memory wait freezes, and discard of stale in-flight fetch responses. Also keeps hazard performance counters.

---
 rtl/rv32i_types.sv | 24 ++
 rtl/hazard_perf_cnt.sv | 39 +++
 rtl/hazard_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/rv32i_types.sv
// Shared rv32i pipeline types: stage control word and hazard controller states.
// Latency: n/a (types only).
// Backpressure: n/a.
package rv32i_types;

  // Per-stage control word carried down the pipeline registers.
  typedef struct packed {
    logic       RegWrite;
    logic       MemtoReg;
    logic       MemRead;
    logic       MemWrite;
    logic       Branch;
    logic       Jump;
    logic       ALUSrc;
    logic [3:0] ALUOp;
  } rv32i_control_word;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    DMEM_WAIT  = 2'd1,
    FETCH_DROP = 2'd2
  } hazard_state_t;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Hazard performance counters: stall cycles and accepted branch flushes.
// Latency: counts visible one cycle after the increment enable.
// Backpressure: none; free-running, wraps modulo 2^CNT_W.
//
// Ports: clk/rst (async active-low), stall_inc_i/flush_inc_i enables,
//        stall_cycles_o/flush_count_o counter values.
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_inc_i,
  input  logic             flush_inc_i,
  output logic [CNT_W-1:0] stall_cycles_o,
  output logic [CNT_W-1:0] flush_count_o
);

  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  always_comb begin
    stall_d = stall_inc_i ? stall_q + CNT_W'(1) : stall_q;
    flush_d = flush_inc_i ? flush_q + CNT_W'(1) : flush_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles_o = stall_q;
  assign flush_count_o  = flush_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, dmem freeze, stale fetch drop.
// Latency: all controls combinational from state and current inputs; counters lag one cycle.
// Backpressure: dmem_resp low freezes every stage; imem_resp low stalls the front end.
//
// Ports: ID_* source regs/uses, EX_RD/EX_control/EX_branch_taken, MEM_control,
//        dmem_resp/imem_resp handshakes in; per-register write/flush/bubble
//        controls and the two performance counters out.
module hazard_ctrl
  import rv32i_types::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        ID_RS1,
  input  logic [4:0]        ID_RS2,
  input  logic              ID_use_rs1,
  input  logic              ID_use_rs2,
  input  logic [4:0]        EX_RD,
  input  rv32i_control_word EX_control,
  input  logic              EX_branch_taken,
  input  rv32i_control_word MEM_control,
  input  logic              dmem_resp,
  input  logic              imem_resp,
  output logic              PC_write,
  output logic              IF_ID_write,
  output logic              IF_ID_flush,
  output logic              ID_EX_write,
  output logic              ID_EX_bubble,
  output logic              EX_MEM_write,
  output logic              MEM_WB_write,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_count
);

  hazard_state_t state_q, state_d;
  logic          drop_q, drop_d;   // stale fetch still owed after a freeze
  logic          dmem_busy, load_use, flush_inc;

  // Only the listed control fields matter here; the rest are sunk.
  logic unused_ctl;
  assign unused_ctl = ^{EX_control.RegWrite, EX_control.MemtoReg, EX_control.MemWrite,
                        EX_control.Branch, EX_control.Jump, EX_control.ALUSrc,
                        EX_control.ALUOp, MEM_control.RegWrite, MEM_control.MemtoReg,
                        MEM_control.Branch, MEM_control.Jump, MEM_control.ALUSrc,
                        MEM_control.ALUOp};

  assign dmem_busy = (MEM_control.MemRead | MEM_control.MemWrite) & ~dmem_resp;
  assign load_use  = EX_control.MemRead & (EX_RD != 5'd0) &
                     ((ID_use_rs1 & (EX_RD == ID_RS1)) | (ID_use_rs2 & (EX_RD == ID_RS2)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    drop_d       = drop_q;
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_write  = 1'b1;
    ID_EX_bubble = 1'b0;
    EX_MEM_write = 1'b1;
    MEM_WB_write = 1'b1;
    flush_inc    = 1'b0;

    if (dmem_busy && state_q != DMEM_WAIT) begin
      // Entering the freeze; remember an owed stale fetch so we return to drop it.
      state_d = DMEM_WAIT;
      drop_d  = (state_q == FETCH_DROP);
    end

    case (state_q)
      DMEM_WAIT: begin
        if (!dmem_busy) begin
          state_d = drop_q ? FETCH_DROP : RUN;
          drop_d  = 1'b0;
        end
      end
      FETCH_DROP: begin
        // Branches are ignored here: EX can only hold a bubble.
        if (!dmem_busy) begin
          PC_write     = 1'b0;
          IF_ID_write  = 1'b0;
          ID_EX_bubble = 1'b1;
          if (imem_resp) state_d = RUN;
        end
      end
      default: begin
        if (!dmem_busy) begin
          if (EX_branch_taken) begin
            IF_ID_flush  = 1'b1;
            ID_EX_bubble = 1'b1;
            flush_inc    = 1'b1;
            if (!imem_resp) state_d = FETCH_DROP;
          end else if (load_use || !imem_resp) begin
            PC_write     = 1'b0;
            IF_ID_write  = 1'b0;
            ID_EX_bubble = 1'b1;
          end
        end
      end
    endcase

    if (dmem_busy) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_write  = 1'b0;
      EX_MEM_write = 1'b0;
      MEM_WB_write = 1'b0;
    end

    // While in reset nothing is held over: pipeline free-runs.
    if (!rst) begin
      PC_write     = 1'b1;
      IF_ID_write  = 1'b1;
      IF_ID_flush  = 1'b0;
      ID_EX_write  = 1'b1;
      ID_EX_bubble = 1'b0;
      EX_MEM_write = 1'b1;
      MEM_WB_write = 1'b1;
      flush_inc    = 1'b0;
    end
  end

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_perf_cnt (
    .clk            (clk),
    .rst            (rst),
    .stall_inc_i    (~PC_write),
    .flush_inc_i    (flush_inc),
    .stall_cycles_o (stall_cycles),
    .flush_count_o  (flush_count)
  );

endmodule
